// File: rtl/hcsr04_scan_controller_pkg.sv
// Shared definitions for the HC-SR04 scan controller: FSM state encodings,
// debug codes, BCD distance width and timer sizing helper.
package hcsr04_scan_controller_pkg;

  localparam int DIST_W = 12;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'h0,
    ST_SELECT = 4'h1,
    ST_PULSE  = 4'h2,
    ST_WAIT   = 4'h3,
    ST_STORE  = 4'h4,
    ST_FAIL   = 4'h5,
    ST_GUARD  = 4'h6,
    ST_DONE   = 4'hF
  } state_t;

  localparam logic [3:0] DB_IDLE    = 4'h0;
  localparam logic [3:0] DB_SELECT  = 4'h1;
  localparam logic [3:0] DB_PULSE   = 4'h2;
  localparam logic [3:0] DB_WAIT    = 4'h3;
  localparam logic [3:0] DB_STORE   = 4'h4;
  localparam logic [3:0] DB_FAIL    = 4'h5;
  localparam logic [3:0] DB_GUARD   = 4'h6;
  localparam logic [3:0] DB_DONE    = 4'hF;
  localparam logic [3:0] DB_ILLEGAL = 4'hE;

  // The shared timer only ever counts 0..max-1, so clog2(max) bits suffice.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 2) ? $clog2(m) : 1;
  endfunction

  function automatic logic [3:0] state_code(input state_t s);
    case (s)
      ST_IDLE:   return DB_IDLE;
      ST_SELECT: return DB_SELECT;
      ST_PULSE:  return DB_PULSE;
      ST_WAIT:   return DB_WAIT;
      ST_STORE:  return DB_STORE;
      ST_FAIL:   return DB_FAIL;
      ST_GUARD:  return DB_GUARD;
      ST_DONE:   return DB_DONE;
      default:   return DB_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/hcsr04_scan_controller_if.sv
// Handshake between the scan controller (master) and the shared HC-SR04
// measurement interface (slave).
interface hcsr04_scan_controller_if;
  import hcsr04_scan_controller_pkg::*;

  logic              medir_if;
  logic              reset_if;
  logic [1:0]        sel;
  logic              pronto_if;
  logic [DIST_W-1:0] medida_if;

  modport master (output medir_if, reset_if, sel, input pronto_if, medida_if);
  modport slave  (input medir_if, reset_if, sel, output pronto_if, medida_if);
endinterface

// File: rtl/hcsr04_scan_controller_scan_timer.sv
// Clearable up-counter with a terminal-count compare, shared by the
// response timeout and the inter-measurement guard interval.
module hcsr04_scan_controller_scan_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             hit
);

  logic [WIDTH-1:0] count_r;

  // Counter register: clear has priority over enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (count_r == limit);

endmodule

// File: rtl/hcsr04_scan_controller.sv
// Round-robin scan of N_CH ultrasonic channels through one shared HC-SR04
// interface, with per-channel result storage, timeout recovery and alerting.
module hcsr04_scan_controller
  import hcsr04_scan_controller_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int TIMEOUT = 2_500_000,
  parameter int GUARD   = 3_000_000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       ligar,
  input  logic [DIST_W-1:0]          limiar,
  hcsr04_scan_controller_if.master   sensor,
  input  logic [1:0]                 rd_sel,
  output logic [DIST_W-1:0]          rd_dist,
  output logic [N_CH-1:0]            valid,
  output logic [N_CH-1:0]            erro,
  output logic                       alerta,
  output logic                       fim_varredura,
  output logic [3:0]                 db_estado
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW   = timer_width(TIMEOUT, GUARD);

  state_t            state_r;
  logic [CH_W-1:0]   ch_r;
  logic [DIST_W-1:0] dist_r [N_CH];
  logic [N_CH-1:0]   valid_r;
  logic [N_CH-1:0]   erro_r;
  logic              medir_r;
  logic              reset_if_r;
  logic              fim_r;

  logic              timer_clear_s;
  logic              timer_enable_s;
  logic [TW-1:0]     timer_limit_s;
  logic              timer_hit_s;

  // Timer control: cleared on the way into WAIT and GUARD, counts inside them.
  always_comb begin
    timer_clear_s  = 1'b0;
    timer_enable_s = 1'b0;
    timer_limit_s  = TW'(GUARD - 1);
    case (state_r)
      ST_PULSE, ST_STORE, ST_FAIL: timer_clear_s = 1'b1;
      ST_WAIT: begin
        timer_enable_s = 1'b1;
        timer_limit_s  = TW'(TIMEOUT - 1);
      end
      ST_GUARD: timer_enable_s = 1'b1;
      default:  timer_clear_s = 1'b0;
    endcase
  end

  hcsr04_scan_controller_scan_timer #(.WIDTH(TW)) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear_s),
    .enable (timer_enable_s),
    .limit  (timer_limit_s),
    .hit    (timer_hit_s)
  );

  // Scan FSM; pulses are registered on the transition into their state so
  // they are high for exactly the cycle spent in PULSE, FAIL or DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ch_r       <= '0;
      valid_r    <= '0;
      erro_r     <= '0;
      medir_r    <= 1'b0;
      reset_if_r <= 1'b0;
      fim_r      <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        dist_r[i] <= '0;
      end
    end else begin
      medir_r    <= 1'b0;
      reset_if_r <= 1'b0;
      fim_r      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ligar) begin
            ch_r    <= '0;
            state_r <= ST_SELECT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SELECT: begin
          medir_r <= 1'b1;
          state_r <= ST_PULSE;
        end
        ST_PULSE: state_r <= ST_WAIT;
        ST_WAIT: begin
          // The sample is only valid alongside pronto_if, so it is captured here.
          if (sensor.pronto_if) begin
            dist_r[ch_r]  <= sensor.medida_if;
            valid_r[ch_r] <= 1'b1;
            erro_r[ch_r]  <= 1'b0;
            state_r       <= ST_STORE;
          end else if (timer_hit_s) begin
            erro_r[ch_r]  <= 1'b1;
            reset_if_r    <= 1'b1;
            state_r       <= ST_FAIL;
          end else begin
            state_r       <= ST_WAIT;
          end
        end
        ST_STORE, ST_FAIL: state_r <= ST_GUARD;
        ST_GUARD: begin
          if (!timer_hit_s) begin
            state_r <= ST_GUARD;
          end else if (ch_r == CH_W'(N_CH - 1)) begin
            fim_r   <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            ch_r    <= ch_r + CH_W'(1);
            state_r <= ST_SELECT;
          end
        end
        ST_DONE: begin
          ch_r    <= '0;
          state_r <= ligar ? ST_SELECT : ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Readback mux; channels beyond N_CH read as zero.
  always_comb begin
    if (int'(rd_sel) < N_CH) begin
      rd_dist = dist_r[CH_W'(rd_sel)];
    end else begin
      rd_dist = '0;
    end
  end

  // BCD digits are ordered, so a plain unsigned compare orders distances.
  always_comb begin
    alerta = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      alerta = alerta | (valid_r[i] & (dist_r[i] < limiar));
    end
  end

  assign sensor.medir_if = medir_r;
  assign sensor.reset_if = reset_if_r;
  assign sensor.sel      = 2'(ch_r);
  assign valid           = valid_r;
  assign erro            = erro_r;
  assign fim_varredura   = fim_r;
  assign db_estado       = state_code(state_r);

endmodule
